// File: rtl/cpu_control_sequencer_if.sv
// Bus bundle between the control sequencer and the rest of the core.
// It carries the instruction-fetch handshake, the instruction register and
// decoder flags, the ALU launch/complete pair, the register-file write strobe,
// and the PC/state/status observation outputs.
//   master : the sequencer. It drives fetch requests, IR, strobes and status.
//   slave  : memory, decoder and ALU. They drive ack/data, flags and alu_done.
interface cpu_control_sequencer_if #(
    parameter int PC_WIDTH = 8
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ack;
    logic [7:0]          imem_data;
    logic [7:0]          ir;
    logic                dec_alu_enable;
    logic                dec_reg_write;
    logic                dec_branch_enable;
    logic                dec_halt;
    logic                alu_start;
    logic                alu_done;
    logic                reg_we;
    logic [3:0]          reg_addr;
    logic [PC_WIDTH-1:0] pc;
    logic [2:0]          state;
    logic                halted;
    logic                stack_err;

    modport master (
        output imem_req, imem_addr, ir, alu_start, reg_we, reg_addr,
               pc, state, halted, stack_err,
        input  imem_ack, imem_data, dec_alu_enable, dec_reg_write,
               dec_branch_enable, dec_halt, alu_done
    );

    modport slave (
        input  imem_req, imem_addr, ir, alu_start, reg_we, reg_addr,
               pc, state, halted, stack_err,
        output imem_ack, imem_data, dec_alu_enable, dec_reg_write,
               dec_branch_enable, dec_halt, alu_done
    );
endinterface

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle control sequencer for the custom processor. It steps through
// fetch, decode, execute/writeback/branch and halt. It owns the PC and a small
// return-address stack for BRANCH (call) and RET.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   step : single-step release, level sampled (only with SINGLE_STEP_EN)
//   bus  : cpu_control_sequencer_if.master. It carries the fetch handshake,
//          IR/decoder flags, ALU start/done, register write strobe, pc,
//          state, halted and stack_err.
// Optional build macro SINGLE_STEP_EN: every return to FETCH goes through
// WAIT_STEP instead. The core then waits for step before fetching the next
// instruction.
module cpu_control_sequencer #(
    parameter int PC_WIDTH  = 8,
    parameter int RET_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef SINGLE_STEP_EN
    input  logic step,
`endif
    cpu_control_sequencer_if.master bus
);
    localparam int SP_WIDTH  = $clog2(RET_DEPTH) + 1;
    localparam int IDX_WIDTH = $clog2(RET_DEPTH);
    localparam logic [SP_WIDTH-1:0] SP_FULL = SP_WIDTH'(RET_DEPTH);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        BRANCH = 3'd4,
        HALT   = 3'd5
`ifdef SINGLE_STEP_EN
        , WAIT_STEP = 3'd6
`endif
    } state_t;

    // The state taken after reset and after each instruction completes.
`ifdef SINGLE_STEP_EN
    localparam state_t RESUME = WAIT_STEP;
`else
    localparam state_t RESUME = FETCH;
`endif

    state_t              state_q;
    state_t              state_d;
    logic [PC_WIDTH-1:0] pc_q;
    logic [7:0]          ir_q;
    logic                imem_req_q;
    logic                alu_start_q;
    logic                reg_we_q;
    logic                halted_q;
    logic                stack_err_q;
    logic [SP_WIDTH-1:0] sp_q;
    logic [PC_WIDTH-1:0] ret_stack [RET_DEPTH];

    logic                 fetch_done;
    logic                 is_call;
    logic                 is_ret;
    logic                 stack_full;
    logic                 stack_empty;
    logic [IDX_WIDTH-1:0] push_idx;
    logic [IDX_WIDTH-1:0] pop_idx;

    // An ack only counts while our own request is up.
    assign fetch_done  = (state_q == FETCH) && imem_req_q && bus.imem_ack;
    assign is_call     = (ir_q[7:4] == 4'b1100);
    assign is_ret      = (ir_q[7:4] == 4'b1011);
    assign stack_full  = (sp_q == SP_FULL);
    assign stack_empty = (sp_q == '0);
    // The stack pointer counts entries, so the top entry sits one slot below it.
    assign push_idx    = sp_q[IDX_WIDTH-1:0];
    assign pop_idx     = push_idx - IDX_WIDTH'(1);

    // The state register. An asynchronous reset abandons any fetch or ALU
    // operation that is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESUME;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection. Decoder flags are looked at only in DECODE, in
    // priority order. alu_done is ignored while alu_start is still high.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (fetch_done) state_d = DECODE;
            end
            DECODE: begin
                if (bus.dec_halt)               state_d = HALT;
                else if (bus.dec_branch_enable) state_d = BRANCH;
                else if (bus.dec_alu_enable)    state_d = EXEC;
                else if (bus.dec_reg_write)     state_d = WB;
                else                            state_d = RESUME;
            end
            EXEC: begin
                if (!alu_start_q && bus.alu_done) state_d = RESUME;
            end
            WB:     state_d = RESUME;
            BRANCH: state_d = RESUME;
            HALT:   state_d = HALT;
`ifdef SINGLE_STEP_EN
            WAIT_STEP: begin
                if (step) state_d = FETCH;
            end
`endif
            default: state_d = RESUME;
        endcase
    end

    // Registered strobes are derived from the state being entered, so each
    // one lines up with its state. This block also holds the PC/IR updates
    // and the return-stack pointer and sticky error bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= '0;
            ir_q        <= '0;
            imem_req_q  <= 1'b0;
            alu_start_q <= 1'b0;
            reg_we_q    <= 1'b0;
            halted_q    <= 1'b0;
            stack_err_q <= 1'b0;
            sp_q        <= '0;
        end else begin
            imem_req_q  <= (state_d == FETCH);
            alu_start_q <= (state_d == EXEC) && (state_q != EXEC);
            reg_we_q    <= (state_d == WB);
            halted_q    <= (state_d == HALT);
            if (fetch_done) begin
                ir_q <= bus.imem_data;
                pc_q <= pc_q + PC_WIDTH'(1);
            end
            if (state_q == BRANCH) begin
                if (is_call) begin
                    // A call on a full stack is still taken. Only the push is lost.
                    pc_q <= PC_WIDTH'(ir_q[3:0]);
                    if (stack_full) stack_err_q <= 1'b1;
                    else            sp_q        <= sp_q + SP_WIDTH'(1);
                end else if (is_ret) begin
                    if (stack_empty) begin
                        stack_err_q <= 1'b1;
                    end else begin
                        pc_q <= ret_stack[pop_idx];
                        sp_q <= sp_q - SP_WIDTH'(1);
                    end
                end
            end
        end
    end

    // Return-stack storage. It has no reset, because the pointer alone
    // decides which entries are live.
    always_ff @(posedge clk) begin
        if (state_q == BRANCH && is_call && !stack_full) begin
            ret_stack[push_idx] <= pc_q;
        end
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc_q;
    assign bus.ir        = ir_q;
    assign bus.alu_start = alu_start_q;
    assign bus.reg_we    = reg_we_q;
    assign bus.reg_addr  = ir_q[3:0];
    assign bus.pc        = pc_q;
    assign bus.state     = state_q;
    assign bus.halted    = halted_q;
    assign bus.stack_err = stack_err_q;
endmodule

// File: doc/cpu_control_sequencer.md
Name: cpu_control_sequencer

Overview:
- Multi-cycle control FSM that sequences the custom processor: fetch, decode, execute, writeback.
- Fetches the opcode byte from instruction memory with a req/ack handshake, latches it into IR and presents it to the instruction decoder.
- Acts on the decoder's alu_enable / reg_write / branch_enable / halt flags by driving ALU start, register-file write and PC updates.
- Owns the PC and a small return-address stack for BRANCH/RET.

Parameters:
- PC_WIDTH, 8, program counter / instruction address width.
- RET_DEPTH, 4, return-address stack entries (power of two, ≥2).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_WIDTH  fetch address (= pc).
- imem_ack  in  1  fetch data valid.
- imem_data  in  8  fetched opcode byte.
- ir  out  8  instruction register; drives decoder opcode input.
- dec_alu_enable  in  1  decoder flag.
- dec_reg_write  in  1  decoder flag.
- dec_branch_enable  in  1  decoder flag.
- dec_halt  in  1  decoder flag.
- alu_start  out  1  one-cycle ALU launch pulse.
- alu_done  in  1  ALU completion.
- reg_we  out  1  one-cycle register-file write strobe.
- reg_addr  out  4  destination register (= ir[3:0]).
- pc  out  PC_WIDTH  program counter.
- state  out  3  current FSM state encoding (debug).
- halted  out  1  core halted.
- stack_err  out  1  sticky return-stack overflow/underflow flag.

Behaviour:
- Reset (async, any state, mid-handshake included):
  - pc=0, ir=0, imem_req=0, alu_start=0, reg_we=0, halted=0, stack_err=0.
  - Stack pointer=0 (empty); state=FETCH.
  - An in-flight fetch or ALU operation is abandoned.
- States: FETCH=0, DECODE=1, EXEC=2, WB=3, BRANCH=4, HALT=5. All outputs are registered.
- FETCH:
  - imem_req=1, imem_addr=pc, both held stable until imem_ack.
  - On the ack cycle: ir<=imem_data, pc<=pc+1 (wraps 2^PC_WIDTH-1 → 0), imem_req<=0, go to DECODE.
  - imem_ack while imem_req=0 is ignored.
- DECODE (1 cycle):
  - Decoder flags are sampled this cycle.
  - Priority: halt → HALT; branch_enable → BRANCH; alu_enable → EXEC; reg_write → WB; none (NOP/undefined) → FETCH.
- EXEC:
  - alu_start pulses high for exactly one cycle on entry.
  - alu_done is sampled from the following cycle onward; on alu_done go to FETCH.
  - alu_done in the same cycle as alu_start is ignored.
- WB:
  - reg_we=1 for one cycle with reg_addr=ir[3:0]; then FETCH.
- BRANCH (1 cycle), selected by ir[7:4]:
  - 4'b1100 (BRANCH):
    - Push pc (already incremented) onto the stack.
    - pc <= zero-extended ir[3:0].
    - Stack full: no push, contents unchanged, stack_err<=1, branch still taken.
  - 4'b1011 (RET):
    - Pop the top entry into pc.
    - Stack empty: pc unchanged (falls through), stack_err<=1.
  - Then FETCH.
- HALT:
  - halted=1; all strobes low; remain in HALT until rst.
- stack_err is cleared only by rst.
- Fetch-to-fetch latency with zero-wait imem_ack (ack in the first FETCH cycle):
  - NOP = 2 cycles.
  - WB/BRANCH = 3 cycles.
  - EXEC = 3 + ALU latency cycles.

Optional Feature:
- SINGLE_STEP_EN defined:
  - Adds input port step (1 bit) and state WAIT_STEP=6.
  - Every transition that would enter FETCH (after reset and after each instruction completes) enters WAIT_STEP instead.
  - WAIT_STEP waits for step=1 (level-sampled), then goes to FETCH. Exactly one instruction executes per step.
  - HALT still has priority.
- SINGLE_STEP_EN undefined:
  - No step port, no WAIT_STEP; the core free-runs.

Test Plan:
- NOP fetch: reset, imem_data=8'h70 acked in 1 cycle at pc=0 → DECODE then FETCH; pc=1; no alu_start/reg_we pulse.
- ALU op: imem_data=8'h13, alu_done 3 cycles after alu_start → exactly one alu_start pulse; next imem_req at pc=1 after alu_done.
- MOV Ri,ACC: 8'hA5 → single reg_we pulse with reg_addr=4'h5.
- Branch/return: at pc=8'h20 fetch 8'hC7 → pc=8'h07, stack holds 8'h21; then fetch 8'hB0 → pc=8'h21, stack empty, stack_err=0.
- Stack boundaries:
  - Underflow: RET with an empty stack → stack_err=1, pc continues sequentially.
  - Overflow: RET_DEPTH+1 BRANCHes → stack_err=1, top entry unchanged.
- Halt and reset: 8'hFF → halted=1, imem_req stays 0 for 20 cycles; assert rst mid-FETCH with imem_req=1 → immediately pc=0, imem_req=0, halted=0.
